sha256_msg_sched: RTL
=====================

# sha256_msg_sched

Sequential SHA-256 message-schedule generator. It accepts one 512-bit padded message block and emits the 64 schedule words W[0]..W[63] in order, one per accepted handshake, with the round index alongside each word. It replaces a fully expanded 64-word W array and a 64:1 word selector with a 16-word sliding window. It sits between the block loader and the compression round datapath; the round logic consumes W[t] together with its own K[t] lookup, indexed by t_out.

## Interface
Parameters:
- none; word width fixed at 32, round count fixed at 64, window depth fixed at 16

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- load_valid  in  1  block_in holds a valid padded block
- load_ready  out  1  block may be accepted (high only in IDLE)
- block_in  in  512  message block; M0 = bits 511:480 … M15 = bits 31:0 (big-endian word order)
- w_valid  out  1  w_out/t_out/w_last valid
- w_ready  in  1  consumer accepts current word
- w_out  out  32  schedule word W[t_out]
- t_out  out  6  round index 0..63
- w_last  out  1  high with W[63]
- busy  out  1  high in RUN

## Operation
- Two states: IDLE, RUN.
- IDLE: load_ready=1, w_valid=0. On load_valid&&load_ready: win[i] <= M_i for i=0..15; t <= 0; go to RUN.
- RUN: load_ready=0, w_valid=1, w_out=win[0], t_out=t, w_last=(t==63). Inputs load_valid and block_in are ignored.
- Accept (w_valid&&w_ready) in RUN:
  - win[i] <= win[i+1] for i=0..14.
  - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], addition mod 2^32 with carries discarded. This is W[t+16].
  - t <= t+1.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x); σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- For t≥48 the computed win[15] is never emitted. It is still computed, and is harmless.
- Accept with t==63: go to IDLE. t wraps to 0. The window is not cleared.
- No accept in RUN (w_ready=0): window, t, and all outputs hold exactly, for any number of cycles.
- reset: state <= IDLE, t <= 0, all 16 window words <= 0. A reset asserted mid-RUN aborts the block; there is no partial output afterwards.

## Timing
- Reset values, first cycle after a reset edge: load_ready=1, w_valid=0, w_out=0, t_out=0, w_last=0, busy=0.
- w_out, t_out, and w_last are driven directly from registers; there is no combinational path from w_ready to any output.
- load_ready and w_valid decode state only; neither depends combinationally on load_valid or w_ready.
- Load accepted at edge N: w_valid=1 with W[0] from cycle N+1.
- With w_ready held at 1: W[0]..W[63] appear on 64 consecutive cycles, N+1..N+64, and load_ready=1 at N+65.
- Minimum block-to-block interval is 65 cycles. No overlap of load with RUN.
- Simultaneous reset and load_valid: reset wins and the block is not captured.
- Simultaneous reset and accept: reset wins and t_out=0.

## Test plan
- Reset, then idle: hold reset 2 cycles, release → load_ready=1, w_valid=0, t_out=0, busy=0 on every cycle until a load.
- "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), w_ready=1:
  - W[0]=0x61626380, W[15]=0x00000018, W[16]=0x61626380, W[17]=0x000F0000, W[63]=0x12B1EDEB.
  - w_last=1 only at t_out=63.
  - Exactly 64 w_valid cycles.
- Back-pressure: same block, w_ready=0 for 5 cycles when t_out=20 → w_out and t_out held at W[20]/20. After release the sequence resumes with no skipped or duplicated index, and W[63] matches the no-stall run.
- Load during RUN: pulse load_valid with a different block_in at t_out=10 → load_ready=0, no capture, and the output sequence is unchanged.
- Mid-run reset: assert reset at t_out=30 for 1 cycle → next cycle w_valid=0, load_ready=1, t_out=0. A subsequent "abc" load reproduces the full correct sequence.
- Back-to-back blocks: present block A with load_valid held high and w_ready=1, then block B → B is captured on the cycle load_ready rises (N+65), and B's W[0] appears at N+66. Checked against a reference model for random A and B.

Source files
------------

// File: rtl/sha256_msg_sched_if.sv
// Handshake bundle between block loader, schedule generator and round datapath.
interface sha256_msg_sched_if;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned T_W     = 6;

  logic               load_valid;
  logic               load_ready;
  logic [BLOCK_W-1:0] block_in;
  logic               w_valid;
  logic               w_ready;
  logic [WORD_W-1:0]  w_out;
  logic [T_W-1:0]     t_out;
  logic               w_last;
  logic               busy;

  // Schedule generator side.
  modport slave (
    input  load_valid,
    input  block_in,
    input  w_ready,
    output load_ready,
    output w_valid,
    output w_out,
    output t_out,
    output w_last,
    output busy
  );

  // Loader / round-logic side.
  modport master (
    output load_valid,
    output block_in,
    output w_ready,
    input  load_ready,
    input  w_valid,
    input  w_out,
    input  t_out,
    input  w_last,
    input  busy
  );
endinterface

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: emits W[0..63] from a 16-word sliding window,
// one word per accepted handshake, with the round index alongside.
module sha256_msg_sched (
  input  logic              clk,
  input  logic              reset,
  sha256_msg_sched_if.slave bus
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_D  = 16;
  localparam int unsigned T_W    = 6;
  localparam int unsigned LAST_T = 63;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [WORD_W-1:0] win_q [WIN_D];
  logic [WORD_W-1:0] win_d [WIN_D];

  logic load_ready_q, load_ready_d;
  logic w_valid_q,    w_valid_d;
  logic busy_q,       busy_d;
  logic w_last_q,     w_last_d;

  logic [WORD_W-1:0] w_new_c;

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return {x[6:0],  x[31:7]}  ^
           {x[17:0], x[31:18]} ^
           {3'b000,  x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^
           {x[18:0], x[31:19]} ^
           {10'b0,   x[31:10]};
  endfunction

  // Next schedule word W[t+16], computed from the current window.
  always_comb begin
    w_new_c = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];
  end

  // Next-state, window and round-index logic.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int i = 0; i < int'(WIN_D); i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (bus.load_valid) begin
          for (int i = 0; i < int'(WIN_D); i++) begin
            win_d[i] = bus.block_in[(int'(WIN_D) - 1 - i) * int'(WORD_W) +: WORD_W];
          end
          t_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.w_ready) begin
          for (int i = 0; i < int'(WIN_D) - 1; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[WIN_D-1] = w_new_c;
          t_d            = t_q + T_W'(1);
          if (t_q == T_W'(LAST_T)) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  // Output flags precomputed from the next state so they leave flops.
  always_comb begin
    load_ready_d = (state_d == IDLE);
    w_valid_d    = (state_d == RUN);
    busy_d       = (state_d == RUN);
    w_last_d     = (state_d == RUN) && (t_d == T_W'(LAST_T));
  end

  // State, window, index and output flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      t_q          <= '0;
      for (int i = 0; i < int'(WIN_D); i++) begin
        win_q[i] <= '0;
      end
      load_ready_q <= 1'b1;
      w_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      w_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      for (int i = 0; i < int'(WIN_D); i++) begin
        win_q[i] <= win_d[i];
      end
      load_ready_q <= load_ready_d;
      w_valid_q    <= w_valid_d;
      busy_q       <= busy_d;
      w_last_q     <= w_last_d;
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.w_valid    = w_valid_q;
  assign bus.busy       = busy_q;
  assign bus.w_last     = w_last_q;
  assign bus.w_out      = win_q[0];
  assign bus.t_out      = t_q;

endmodule
